// File: rtl/game_pkg.sv
// Shared game definitions: FSM state encoding, playfield geometry
// and small helpers used by top, frog and game_ctrl.
package game_pkg;

  typedef enum logic [1:0] {
    ST_TITLE = 2'b00,
    ST_PLAY  = 2'b01,
    ST_DYING = 2'b10,
    ST_OVER  = 2'b11
  } game_state_t;

  localparam int BLOCKSIZE = 32;

  localparam int LANE_GOAL_Y   = 1 * BLOCKSIZE;
  localparam int LANE_RIVER0_Y = 2 * BLOCKSIZE;
  localparam int LANE_RIVER1_Y = 3 * BLOCKSIZE;
  localparam int LANE_RIVER2_Y = 4 * BLOCKSIZE;
  localparam int LANE_BANK_Y   = 5 * BLOCKSIZE;
  localparam int LANE_ROAD0_Y  = 6 * BLOCKSIZE;
  localparam int LANE_ROAD1_Y  = 7 * BLOCKSIZE;
  localparam int LANE_ROAD2_Y  = 8 * BLOCKSIZE;
  localparam int LANE_START_Y  = 9 * BLOCKSIZE;

  function automatic logic [1:0] dec_sat2(
    input logic [1:0] v
  );
    return (v == 2'd0) ? 2'd0 : v - 2'd1;
  endfunction

endpackage

// File: rtl/rise_detect.sv
// Single-bit rising-edge detector: one history register,
// output is high for the one cycle where d goes 0 -> 1.
module rise_detect (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic rise
);

  logic q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) q <= 1'b0;
    else          q <= d;
  end

  assign rise = d & ~q;

endmodule

// File: rtl/game_ctrl.sv
// Game-level sequencer: title / play / dying / game-over flow,
// lives and score keeping, one-cycle respawn and audio pulses.
module game_ctrl
  import game_pkg::*;
#(
  parameter int unsigned START_LIVES  = 3,
  parameter int unsigned WIN_SCORE    = 5,
  parameter int unsigned DEATH_FRAMES = 30,
  parameter int unsigned OVER_FRAMES  = 60
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       collision,
  input  logic       reached_end,
  output logic [1:0] state,
  output logic [1:0] lives,
  output logic [7:0] score,
  output logic       game_won,
  output logic       respawn,
  output logic       win_pulse,
  output logic       lose_pulse
);

  localparam logic [1:0] LIVES_L = 2'(START_LIVES);
  localparam logic [7:0] WIN_L   = 8'(WIN_SCORE);
  localparam logic [7:0] DEATH_L = 8'(DEATH_FRAMES);
  localparam logic [7:0] OVER_L  = 8'(OVER_FRAMES);

  game_state_t st;
  logic [7:0]  cnt;
  logic        start_rise;
  logic        coll_rise;
  logic        end_rise;
  logic        new_game;
  logic [7:0]  score_inc;

  rise_detect u_start_rd (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (start),
    .rise    (start_rise)
  );

  rise_detect u_coll_rd (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (collision),
    .rise    (coll_rise)
  );

  rise_detect u_end_rd (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (reached_end),
    .rise    (end_rise)
  );

  assign state     = st;
  assign score_inc = score + 8'd1;

  // A game-over screen only accepts start once its timer has saturated.
  assign new_game = start_rise &
                    ((st == ST_TITLE) |
                     ((st == ST_OVER) & (cnt == OVER_L)));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st         <= ST_TITLE;
      lives      <= LIVES_L;
      score      <= 8'd0;
      game_won   <= 1'b0;
      respawn    <= 1'b0;
      win_pulse  <= 1'b0;
      lose_pulse <= 1'b0;
      cnt        <= 8'd0;
    end else begin
      respawn    <= 1'b0;
      win_pulse  <= 1'b0;
      lose_pulse <= 1'b0;
      if (new_game) begin
        st       <= ST_PLAY;
        lives    <= LIVES_L;
        score    <= 8'd0;
        game_won <= 1'b0;
        respawn  <= 1'b1;
        cnt      <= 8'd0;
      end else begin
        unique case (st)
          ST_TITLE: begin
            cnt <= 8'd0;
          end
          ST_PLAY: begin
            if (end_rise) begin
              score   <= score_inc;
              respawn <= 1'b1;
              if (score_inc == WIN_L) begin
                game_won  <= 1'b1;
                win_pulse <= 1'b1;
                st        <= ST_OVER;
                cnt       <= 8'd0;
              end
            end else if (coll_rise) begin
              lives <= dec_sat2(lives);
              st    <= ST_DYING;
              cnt   <= 8'd0;
            end
          end
          ST_DYING: begin
            if (cnt == DEATH_L) begin
              cnt <= 8'd0;
              if (lives == 2'd0) begin
                game_won   <= 1'b0;
                lose_pulse <= 1'b1;
                st         <= ST_OVER;
              end else begin
                respawn <= 1'b1;
                st      <= ST_PLAY;
              end
            end else if (frame_tick) begin
              cnt <= cnt + 8'd1;
            end
          end
          ST_OVER: begin
            if (frame_tick && (cnt != OVER_L))
              cnt <= cnt + 8'd1;
          end
        endcase
      end
    end
  end

endmodule
